// File: rtl/median_stream_ctrl.sv
// median_stream_ctrl: sequences a frame of samples through an external
// combinational 3-input median unit to form a 3-tap sliding-window median
// filter with edge replication, and presents each result on a registered
// valid/ready output stream.
module median_stream_ctrl #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] med_a0,
    output logic [DATA_W-1:0] med_a1,
    output logic [DATA_W-1:0] med_a2,
    input  logic [DATA_W-1:0] med_out,
    output logic              busy,
    output logic              done
);

    // Index of the last sample in a frame, and the degenerate one-sample case.
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(FRAME_LEN - 1);
    localparam bit               SINGLE_SMP = (FRAME_LEN == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [DATA_W-1:0]   prev;
    logic [DATA_W-1:0]   cur;
    logic [CNT_W-1:0]    in_cnt;
    logic [CNT_W-1:0]    out_cnt;

    logic [DATA_W-1:0]   prev_nxt;
    logic [DATA_W-1:0]   cur_nxt;
    logic [CNT_W-1:0]    in_cnt_nxt;
    logic [CNT_W-1:0]    out_cnt_nxt;
    logic [DATA_W-1:0]   out_data_nxt;
    logic                out_valid_nxt;
    logic                done_nxt;

    logic                slot_free;
    logic                out_hs;
    logic                in_hs;

    // The output register can take a new result when empty or being drained.
    assign slot_free = !out_valid || out_ready;
    assign out_hs    = out_valid && out_ready;
    assign in_hs     = in_valid && in_ready;
    assign busy      = (state != S_IDLE);

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            prev      <= '0;
            cur       <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            prev      <= prev_nxt;
            cur       <= cur_nxt;
            in_cnt    <= in_cnt_nxt;
            out_cnt   <= out_cnt_nxt;
            out_data  <= out_data_nxt;
            out_valid <= out_valid_nxt;
            done      <= done_nxt;
        end
    end

    // Next-state, window update, median input selection and stream handshakes.
    always_comb begin
        state_nxt     = state;
        prev_nxt      = prev;
        cur_nxt       = cur;
        in_cnt_nxt    = in_cnt;
        out_cnt_nxt   = out_cnt;
        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;
        done_nxt      = 1'b0;
        in_ready      = 1'b0;
        med_a0        = prev;
        med_a1        = cur;
        med_a2        = cur;

        // A consumed result empties the register unless reloaded below.
        if (out_hs) begin
            out_cnt_nxt   = out_cnt + CNT_W'(1);
            out_valid_nxt = 1'b0;
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    in_cnt_nxt  = '0;
                    out_cnt_nxt = '0;
                    state_nxt   = S_FILL;
                end
            end

            // First sample seeds both window taps (left-edge replication).
            S_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    prev_nxt   = in_data;
                    cur_nxt    = in_data;
                    in_cnt_nxt = CNT_W'(1);
                    state_nxt  = SINGLE_SMP ? S_FLUSH : S_RUN;
                end
            end

            // Each accepted sample completes the window centred on cur.
            S_RUN: begin
                in_ready = slot_free;
                med_a2   = in_data;
                if (in_hs) begin
                    out_data_nxt  = med_out;
                    out_valid_nxt = 1'b1;
                    prev_nxt      = cur;
                    cur_nxt       = in_data;
                    in_cnt_nxt    = in_cnt + CNT_W'(1);
                    if (in_cnt == LAST_IDX) begin
                        state_nxt = S_FLUSH;
                    end
                end
            end

            // Last output uses the replicated right edge (a2 = cur).
            S_FLUSH: begin
                if (slot_free) begin
                    out_data_nxt  = med_out;
                    out_valid_nxt = 1'b1;
                    state_nxt     = S_DRAIN;
                end
            end

            // Wait for the final result to be taken, then signal completion.
            S_DRAIN: begin
                if (out_hs) begin
                    done_nxt      = 1'b1;
                    out_valid_nxt = 1'b0;
                    state_nxt     = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
